// File: rtl/vsync_format_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | vsync_format_monitor                                                     |
// | Continuous PAL/NTSC classifier from the VSYNC falling-edge period.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vsync_format_monitor #(
   parameter int CNT_W          = 21,
   parameter int THRESHOLD_CYC  = 900000,
   parameter int MIN_PERIOD_CYC = 750000,
   parameter int MAX_PERIOD_CYC = 1100000,
   parameter int CONFIRM_N      = 3
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             vsync_in,
   output logic             format_valid,
   output logic             format_type,
   output logic             format_changed,
   output logic [CNT_W-1:0] period_out,
   output logic             signal_lost
);

   localparam logic             FORMAT_NTSC = 1'b0;
   localparam logic [CNT_W-1:0] C_THR       = CNT_W'(THRESHOLD_CYC);
   localparam logic [CNT_W-1:0] C_MIN       = CNT_W'(MIN_PERIOD_CYC);
   localparam logic [CNT_W-1:0] C_MAX       = CNT_W'(MAX_PERIOD_CYC);
   localparam logic [3:0]       C_CONFIRM   = 4'(CONFIRM_N);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       match_q, match_d;
   logic             cand_q, cand_d;
   logic             valid_q, valid_d;
   logic             type_q, type_d;
   logic             changed_q, changed_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             lost_q, lost_d;

   logic w_fall;
   logic w_timeout;
   logic w_invalid;
   logic w_class;

   always_comb begin
      state_d   = state_q;
      sync_d    = {sync_q[1:0], vsync_in};
      cnt_d     = cnt_q;
      match_d   = match_q;
      cand_d    = cand_q;
      valid_d   = valid_q;
      type_d    = type_q;
      changed_d = 1'b0;
      period_d  = period_q;
      lost_d    = lost_q;

      // sync_q[2] is the oldest sample: high-then-low marks a falling edge
      w_fall    = sync_q[2] & ~sync_q[1];
      w_timeout = (state_q != ST_IDLE) && (cnt_q == C_MAX);
      w_invalid = (cnt_q < C_MIN);
      w_class   = (cnt_q > C_THR);

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (w_fall) begin
               cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
               state_d = ST_MEASURE;
               lost_d  = 1'b0;
            end
         end
         default: begin
            if (w_timeout) begin
               valid_d = 1'b0;
               lost_d  = 1'b1;
               match_d = '0;
               // A coincident edge still starts the next measurement
               if (w_fall) begin
                  cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                  state_d = ST_MEASURE;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end else if (w_fall) begin
               cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
               lost_d = 1'b0;
               if (w_invalid) begin
                  match_d = '0;
               end else begin
                  period_d = cnt_q;
                  if ((w_class == cand_q) && (match_q != 4'd0)) begin
                     match_d = (match_q >= C_CONFIRM) ? C_CONFIRM : match_q + 4'd1;
                  end else begin
                     cand_d  = w_class;
                     match_d = 4'd1;
                  end
                  if (match_d == C_CONFIRM) begin
                     if (state_q == ST_MEASURE) begin
                        valid_d = 1'b1;
                        type_d  = cand_d;
                        state_d = ST_LOCKED;
                     end else if (cand_d != type_q) begin
                        type_d    = cand_d;
                        changed_d = 1'b1;
                     end
                  end
               end
            end else begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q   <= ST_IDLE;
         sync_q    <= 3'b111;
         cnt_q     <= '0;
         match_q   <= '0;
         cand_q    <= FORMAT_NTSC;
         valid_q   <= 1'b0;
         type_q    <= FORMAT_NTSC;
         changed_q <= 1'b0;
         period_q  <= '0;
         lost_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         match_q   <= match_d;
         cand_q    <= cand_d;
         valid_q   <= valid_d;
         type_q    <= type_d;
         changed_q <= changed_d;
         period_q  <= period_d;
         lost_q    <= lost_d;
      end
   end

   assign format_valid   = valid_q;
   assign format_type    = type_q;
   assign format_changed = changed_q;
   assign period_out     = period_q;
   assign signal_lost    = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_vsync_format_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vsync_format_monitor                                                  |
// | Directed vector bench for the VSYNC PAL/NTSC format monitor.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vsync_format_monitor;

   localparam int CNT_W = 12;

   logic             clk_in   = 1'b0;
   logic             reset_in = 1'b1;
   logic             vsync_in = 1'b1;
   logic             format_valid;
   logic             format_type;
   logic             format_changed;
   logic [CNT_W-1:0] period_out;
   logic             signal_lost;

   always #5 clk_in = ~clk_in;

   vsync_format_monitor #(
      .CNT_W          (CNT_W),
      .THRESHOLD_CYC  (900),
      .MIN_PERIOD_CYC (750),
      .MAX_PERIOD_CYC (1100),
      .CONFIRM_N      (3)
   ) dut (
      .clk_in         (clk_in),
      .reset_in       (reset_in),
      .vsync_in       (vsync_in),
      .format_valid   (format_valid),
      .format_type    (format_type),
      .format_changed (format_changed),
      .period_out     (period_out),
      .signal_lost    (signal_lost)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Pulse bookkeeping: rising edges counted, over-long pulses flagged
   int chg_total = 0;
   int chg_long  = 0;
   bit chg_prev  = 1'b0;
   always @(negedge clk_in) begin
      if (format_changed && chg_prev)  chg_long++;
      if (format_changed && !chg_prev) chg_total++;
      chg_prev = format_changed;
   end

   typedef struct {
      bit do_rst;
      int len;
      int goff;
      bit v;
      bit t;
      int p;
      int chg;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input int v, input int t, input int p);
      check({tag, "_valid"},  32'(format_valid), 32'(v));
      check({tag, "_type"},   32'(format_type),  32'(t));
      check({tag, "_period"}, 32'(period_out),   32'(p));
   endtask

   // One frame: 20-cycle low sync pulse, optional 40-cycle glitch at goff
   task automatic frame(input int len, input int goff);
      for (int i = 0; i < len; i++) begin
         @(negedge clk_in);
         vsync_in = (i < 20 || (goff > 0 && i >= goff && i < goff + 40)) ? 1'b0 : 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      vsync_in = 1'b1;
      reset_in = 1'b1;
      repeat (3) @(negedge clk_in);
      check_out("rst", 0, 0, 0);
      check("rst_changed", 32'(format_changed), 32'd0);
      check("rst_lost",    32'(signal_lost),    32'd0);
      reset_in = 1'b0;
      repeat (3) @(negedge clk_in);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;

      //            rst   len  goff v  t  p     chg
      vecs[0]  = '{1'b1, 1000, 0, 1'b0, 1'b0, 0,    0};
      vecs[1]  = '{1'b0, 1000, 0, 1'b0, 1'b0, 1000, 0};
      vecs[2]  = '{1'b0, 1000, 0, 1'b0, 1'b0, 1000, 0};
      vecs[3]  = '{1'b0, 834,  0, 1'b1, 1'b1, 1000, 0};
      vecs[4]  = '{1'b0, 834,  0, 1'b1, 1'b1, 834,  0};
      vecs[5]  = '{1'b0, 834,  0, 1'b1, 1'b1, 834,  0};
      vecs[6]  = '{1'b0, 900,  0, 1'b1, 1'b0, 834,  1};
      vecs[7]  = '{1'b0, 901,  0, 1'b1, 1'b0, 900,  0};
      vecs[8]  = '{1'b0, 901,  0, 1'b1, 1'b0, 901,  0};
      vecs[9]  = '{1'b0, 901,  0, 1'b1, 1'b0, 901,  0};
      vecs[10] = '{1'b0, 750,  0, 1'b1, 1'b1, 901,  1};
      vecs[11] = '{1'b0, 749,  0, 1'b1, 1'b1, 750,  0};
      vecs[12] = '{1'b0, 1000, 0, 1'b1, 1'b1, 750,  0};
      vecs[13] = '{1'b0, 750,  0, 1'b1, 1'b1, 1000, 0};
      vecs[14] = '{1'b1, 834,  0, 1'b0, 1'b0, 0,    0};
      vecs[15] = '{1'b0, 834,  0, 1'b0, 1'b0, 834,  0};
      vecs[16] = '{1'b0, 834,  0, 1'b0, 1'b0, 834,  0};
      vecs[17] = '{1'b0, 834,  0, 1'b1, 1'b0, 834,  0};

      // Exact lock latency on the 4th edge of a 1000-cycle stream
      do_reset();
      repeat (3) frame(1000, 0);
      @(negedge clk_in);
      vsync_in = 1'b0;
      @(negedge clk_in);
      check("lat_edge_n",  32'(format_valid), 32'd0);
      @(negedge clk_in);
      check("lat_edge_n1", 32'(format_valid), 32'd0);
      @(negedge clk_in);
      check_out("lat_edge_n2", 1, 1, 1000);
      repeat (17) @(negedge clk_in);
      vsync_in = 1'b1;
      repeat (10) @(negedge clk_in);

      for (int i = 0; i < 18; i++) begin
         if (vecs[i].do_rst) do_reset();
         c0 = chg_total;
         frame(vecs[i].len, vecs[i].goff);
         check_out($sformatf("vec%0d", i), int'(vecs[i].v), int'(vecs[i].t), vecs[i].p);
         check($sformatf("vec%0d_chg", i), 32'(chg_total - c0), 32'(vecs[i].chg));
      end

      // Loss of signal, then recovery with 1000-cycle frames
      frame(1000, 0);
      repeat (95) @(negedge clk_in);
      check("lost_before_valid", 32'(format_valid), 32'd1);
      check("lost_before_flag",  32'(signal_lost),  32'd0);
      repeat (15) @(negedge clk_in);
      check("lost_after_valid", 32'(format_valid), 32'd0);
      check("lost_after_flag",  32'(signal_lost),  32'd1);
      check("lost_after_type",  32'(format_type),  32'd0);
      c0 = chg_total;
      frame(1000, 0);
      check("resume1_flag", 32'(signal_lost), 32'd0);
      check_out("resume1", 0, 0, 834);
      frame(1000, 0);
      check_out("resume2", 0, 0, 1000);
      frame(1000, 0);
      check_out("resume3", 0, 0, 1000);
      frame(1000, 0);
      check_out("resume4", 1, 1, 1000);
      check("resume_chg", 32'(chg_total - c0), 32'd0);

      // Glitch inside a locked PAL stream
      frame(1000, 500);
      check_out("glitch_a", 1, 1, 1000);
      frame(1000, 0);
      check_out("glitch_b", 1, 1, 1000);

      // Glitch must restart the NTSC confirmation count
      frame(834, 0);
      frame(834, 0);
      c0 = chg_total;
      frame(1000, 500);
      check_out("restart_glitch", 1, 1, 834);
      frame(834, 0);
      frame(834, 0);
      check_out("restart_m1", 1, 1, 834);
      frame(834, 0);
      check_out("restart_m2", 1, 1, 834);
      frame(834, 0);
      check_out("restart_m3", 1, 0, 834);
      check("restart_chg", 32'(chg_total - c0), 32'd1);

      // Relock PAL, then asynchronous reset mid-frame
      frame(400, 0);
      repeat (4) frame(1000, 0);
      frame(400, 0);
      check_out("pre_areset", 1, 1, 1000);
      #2;
      reset_in = 1'b1;
      #1;
      check_out("areset", 0, 0, 0);
      check("areset_lost", 32'(signal_lost), 32'd0);
      repeat (3) @(negedge clk_in);
      vsync_in = 1'b1;
      reset_in = 1'b0;
      repeat (3) @(negedge clk_in);
      c0 = chg_total;
      repeat (4) frame(1000, 0);
      check_out("post_areset", 1, 1, 1000);
      check("post_areset_chg", 32'(chg_total - c0), 32'd0);

      check("chg_single_cycle", 32'(chg_long), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
